// File: rtl/pc_pkg.sv
// Shared fetch-stage definitions: next-PC source encoding and the default
// step and vector values that decode also relies on.
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_JUMP,
      SRC_BRANCH,
      SRC_RET,
      SRC_TRAP
   } pc_src_e;

   localparam int          DEFAULT_STEP         = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0004;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push into a full stack silently replaces
// the oldest entry; a pop together with a push replaces the top in place.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             overwrite,
   output logic             underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    ptr_reg, ptr_next, wr_idx;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_pop;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CW'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign overwrite = push & full & ~do_pop;
   assign underflow = pop & empty;
   assign top       = mem[ptr_reg];

   always_comb begin
      ptr_next   = ptr_reg;
      count_next = count_reg;
      wr_idx     = ptr_reg;
      if (do_pop && push) begin
         // pop-then-push collapses to rewriting the current top slot
         wr_idx = ptr_reg;
      end else if (do_pop) begin
         ptr_next   = ptr_reg - PW'(1);
         count_next = count_reg - CW'(1);
      end else if (push) begin
         ptr_next = ptr_reg + PW'(1);
         wr_idx   = ptr_reg + PW'(1);
         if (!full) begin
            count_next = count_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_reg   <= '0;
         count_reg <= '0;
      end else begin
         ptr_reg   <= ptr_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_idx] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: prioritised next-PC selection, target
// alignment check, return-address prediction and sticky RAS error flags.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
   parameter int              STEP         = DEFAULT_STEP,
   parameter int              RAS_DEPTH    = 4,
   parameter int              ALIGN_BITS   = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            stall,
   input  logic            trap,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            call,
   input  logic            ret,
   input  logic [XLEN-1:0] ret_target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_step,
   output logic            misaligned,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

   logic [XLEN-1:0] pc_reg, pc_next, raw_target, ras_top;
   logic            misaligned_reg, misaligned_next;
   logic            overflow_reg, underflow_reg;
   logic            hold, redirect, ras_active, ras_push, ras_pop;
   logic            ras_overwrite, ras_underflow_event;
   pc_src_e         src;

   assign pc_plus_step = pc_reg + XLEN'(STEP);
   assign hold         = stall & ~trap;
   // The RAS only moves when the return/call actually steers the PC
   assign ras_active   = ~trap & ~stall & ~branch_taken;
   assign ras_push     = ras_active & call;
   assign ras_pop      = ras_active & ret;

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (XLEN)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus_step),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overwrite (ras_overwrite),
      .underflow (ras_underflow_event)
   );

   always_comb begin
      src = SRC_SEQ;
      if (trap)              src = SRC_TRAP;
      else if (branch_taken) src = SRC_BRANCH;
      else if (ret)          src = SRC_RET;
      else if (jump)         src = SRC_JUMP;
   end

   always_comb begin
      raw_target = pc_plus_step;
      redirect   = 1'b0;
      case (src)
         SRC_BRANCH: begin raw_target = branch_target; redirect = 1'b1; end
         SRC_RET: begin
            raw_target = ras_empty ? ret_target : ras_top;
            redirect   = 1'b1;
         end
         SRC_JUMP:   begin raw_target = jump_target; redirect = 1'b1; end
         default:    ;
      endcase
   end

   always_comb begin
      pc_next         = pc_plus_step;
      misaligned_next = 1'b0;
      if (hold) begin
         pc_next         = pc_reg;
         misaligned_next = misaligned_reg;
      end else if (src == SRC_TRAP) begin
         pc_next = TRAP_VECTOR;
      end else if (redirect) begin
         pc_next         = raw_target & ~ALIGN_MASK;
         misaligned_next = |(raw_target & ALIGN_MASK);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_reg         <= RESET_VECTOR;
         misaligned_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
      end else begin
         pc_reg         <= pc_next;
         misaligned_reg <= misaligned_next;
         overflow_reg   <= overflow_reg | ras_overwrite;
         underflow_reg  <= underflow_reg | ras_underflow_event;
      end
   end

   assign pc            = pc_reg;
   assign misaligned    = misaligned_reg;
   assign ras_overflow  = overflow_reg;
   assign ras_underflow = underflow_reg;

endmodule
